// File: rtl/tt_sweep_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : tt_sweep_ctrl_if
// Description : Signal bundle between a truth-table sweep controller and its
//               host plus the two combinational netlists it exercises.
//               slave  = controller side, master = host/netlist side.
// Revision    : 1.0 - initial release
// ============================================================================
interface tt_sweep_ctrl_if #(
  parameter int N_IN = 6
);
  // Host control
  logic                    start;
  logic                    abort;
  // Netlist bus
  logic [N_IN-1:0]         x;
  logic                    y_dut;
  logic                    y_ref;
  // Status and results
  logic                    busy;
  logic                    done;
  logic [(1<<N_IN)-1:0]    tt;
  logic [N_IN:0]           mism_cnt;
  logic [N_IN-1:0]         first_mism;
  logic                    first_valid;
  logic                    pass;
  logic [15:0]             sig;

  modport master (
    output start, abort, y_dut, y_ref,
    input  x, busy, done, tt, mism_cnt, first_mism, first_valid, pass, sig
  );

  modport slave (
    input  start, abort, y_dut, y_ref,
    output x, busy, done, tt, mism_cnt, first_mism, first_valid, pass, sig
  );
endinterface
`default_nettype wire

// File: rtl/tt_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tt_sweep_ctrl
// Description : Exhaustive truth-table sweep controller. Walks x through all
//               2^N_IN vectors, waits SETTLE cycles per vector, then samples
//               y_dut/y_ref, capturing the DUT truth table, mismatch count and
//               first failing vector.
//               Optional macro TT_MISR_EN adds a 16-bit MISR signature
//               (x^16+x^12+x^5+1) over the sampled y_dut stream; without it
//               sig is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module tt_sweep_ctrl #(
  parameter int N_IN   = 6,
  parameter int SETTLE = 1
) (
  input wire              clk,
  input wire              rst_n,
  tt_sweep_ctrl_if.slave  io_sweep
);

  localparam logic [N_IN-1:0] C_X_LAST    = {N_IN{1'b1}};
  localparam logic [N_IN-1:0] C_X_ONE     = N_IN'(1);
  localparam logic [N_IN:0]   C_MISM_ONE  = (N_IN+1)'(1);
  localparam logic [3:0]      C_SETTLE_LD = 4'(SETTLE);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;

  logic [N_IN-1:0]         r_x;
  logic [3:0]              r_cnt;
  logic                    r_busy;
  logic                    r_done;
  logic [(1<<N_IN)-1:0]    r_tt;
  logic [N_IN:0]           r_mism;
  logic [N_IN-1:0]         r_first_mism;
  logic                    r_first_valid;
  logic                    r_pass;

  // Control strobes produced by the next-state logic
  logic                    w_accept;
  logic                    w_sample;
  logic                    w_last;
  logic                    w_fin;
  logic                    w_abort;
  logic                    w_dec;
  logic                    w_miscompare;

  assign w_miscompare = io_sweep.y_dut ^ io_sweep.y_ref;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and strobe decode; abort outranks sampling so an aborted
  // SAMPLE cycle leaves no trace in the results
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_sample    = 1'b0;
    w_last      = 1'b0;
    w_fin       = 1'b0;
    w_abort     = 1'b0;
    w_dec       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (io_sweep.start) begin
          w_accept = 1'b1;
          if (SETTLE > 0) begin
            w_state_nxt = S_SETTLE;
          end else begin
            w_state_nxt = S_SAMPLE;
          end
        end
      end
      S_SETTLE: begin
        if (io_sweep.abort) begin
          w_abort     = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_cnt == 4'd1) begin
          w_state_nxt = S_SAMPLE;
        end else begin
          w_dec = 1'b1;
        end
      end
      S_SAMPLE: begin
        if (io_sweep.abort) begin
          w_abort     = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_sample = 1'b1;
          if (r_x == C_X_LAST) begin
            w_last      = 1'b1;
            w_state_nxt = S_FINISH;
          end else if (SETTLE > 0) begin
            w_state_nxt = S_SETTLE;
          end else begin
            w_state_nxt = S_SAMPLE;
          end
        end
      end
      S_FINISH: begin
        w_state_nxt = S_IDLE;
        if (io_sweep.abort) begin
          w_abort = 1'b1;
        end else begin
          w_fin = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath: vector stepping, settle counter, result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x           <= '0;
      r_cnt         <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_tt          <= '0;
      r_mism        <= '0;
      r_first_mism  <= '0;
      r_first_valid <= 1'b0;
      r_pass        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_x           <= '0;
        r_cnt         <= C_SETTLE_LD;
        r_busy        <= 1'b1;
        r_tt          <= '0;
        r_mism        <= '0;
        r_first_valid <= 1'b0;
        r_pass        <= 1'b0;
      end
      if (w_dec) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_abort) begin
        r_busy <= 1'b0;
        r_x    <= '0;
      end
      if (w_sample) begin
        r_tt[r_x] <= io_sweep.y_dut;
        if (w_miscompare) begin
          r_mism <= r_mism + C_MISM_ONE;
          if (!r_first_valid) begin
            r_first_mism  <= r_x;
            r_first_valid <= 1'b1;
          end
        end
        if (w_last) begin
          r_done <= 1'b1;
        end else begin
          r_x   <= r_x + C_X_ONE;
          r_cnt <= C_SETTLE_LD;
        end
      end
      if (w_fin) begin
        r_busy <= 1'b0;
        r_x    <= '0;
        r_pass <= (r_mism == '0);
      end
    end
  end

`ifdef TT_MISR_EN
  localparam logic [15:0] C_MISR_SEED = 16'hFFFF;
  // Taps for x^12 and x^5; the x^0 term is folded into bit 0 with y_dut
  localparam logic [15:0] C_MISR_TAPS = 16'h1020;

  logic [15:0] r_sig;
  logic        w_fb;
  logic [15:0] w_sig_nxt;

  assign w_fb      = r_sig[15];
  assign w_sig_nxt = {r_sig[14:0], w_fb ^ io_sweep.y_dut} ^ ({16{w_fb}} & C_MISR_TAPS);

  // Signature register: seeded on start, one shift per sampled vector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig <= 16'h0000;
    end else if (w_accept) begin
      r_sig <= C_MISR_SEED;
    end else if (w_sample) begin
      r_sig <= w_sig_nxt;
    end
  end

  assign io_sweep.sig = r_sig;
`else
  assign io_sweep.sig = 16'h0000;
`endif

  assign io_sweep.x           = r_x;
  assign io_sweep.busy        = r_busy;
  assign io_sweep.done        = r_done;
  assign io_sweep.tt          = r_tt;
  assign io_sweep.mism_cnt    = r_mism;
  assign io_sweep.first_mism  = r_first_mism;
  assign io_sweep.first_valid = r_first_valid;
  assign io_sweep.pass        = r_pass;

endmodule
`default_nettype wire

// File: tb/tb_tt_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_tt_sweep_ctrl
// Description : Self-checking bench for tt_sweep_ctrl. Two instances
//               (SETTLE=1 and SETTLE=0) share a clock and reset; the bench
//               models the netlists as lookup tables and predicts results
//               from the table contents directly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tt_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_req;
  logic        abort_req;
  logic        sel;          // 0 = instance A (SETTLE=1), 1 = instance B (SETTLE=0)
  logic [63:0] ref_tbl;      // reference netlist truth table
  logic [63:0] err_mask;     // vectors where the DUT netlist disagrees

  int n_checks;
  int n_errors;

  always #5 clk = ~clk;

  tt_sweep_ctrl_if #(.N_IN(6)) if_a ();
  tt_sweep_ctrl_if #(.N_IN(6)) if_b ();

  tt_sweep_ctrl #(.N_IN(6), .SETTLE(1)) u_dut_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .io_sweep (if_a)
  );

  tt_sweep_ctrl #(.N_IN(6), .SETTLE(0)) u_dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .io_sweep (if_b)
  );

  assign if_a.start = start_req & ~sel;
  assign if_b.start = start_req &  sel;
  assign if_a.abort = abort_req & ~sel;
  assign if_b.abort = abort_req &  sel;

  // Combinational netlists under test
  assign if_a.y_ref = ref_tbl[if_a.x];
  assign if_a.y_dut = ref_tbl[if_a.x] ^ err_mask[if_a.x];
  assign if_b.y_ref = ref_tbl[if_b.x];
  assign if_b.y_dut = ref_tbl[if_b.x] ^ err_mask[if_b.x];

  // Observed outputs of the selected instance
  logic [5:0]  o_x;
  logic        o_busy, o_done, o_fv, o_pass;
  logic [63:0] o_tt;
  logic [6:0]  o_mism;
  logic [5:0]  o_first;
  logic [15:0] o_sig;

  assign o_x     = sel ? if_b.x           : if_a.x;
  assign o_busy  = sel ? if_b.busy        : if_a.busy;
  assign o_done  = sel ? if_b.done        : if_a.done;
  assign o_tt    = sel ? if_b.tt          : if_a.tt;
  assign o_mism  = sel ? if_b.mism_cnt    : if_a.mism_cnt;
  assign o_first = sel ? if_b.first_mism  : if_a.first_mism;
  assign o_fv    = sel ? if_b.first_valid : if_a.first_valid;
  assign o_pass  = sel ? if_b.pass        : if_a.pass;
  assign o_sig   = sel ? if_b.sig         : if_a.sig;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int lowest_set(input logic [63:0] m);
    for (int i = 0; i < 64; i++) begin
      if (m[i]) return i;
    end
    return 0;
  endfunction

  // CRC-style signature of the first n truth-table bits, polynomial 0x1021
  function automatic logic [15:0] misr_ref(input logic [63:0] t, input int n);
    logic [15:0] s;
    s = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      s = (s << 1) ^ (s[15] ? 16'h1021 : 16'h0000) ^ {15'd0, t[i]};
    end
    return s;
  endfunction

  function automatic logic [15:0] exp_sig(input logic [63:0] t, input int n);
`ifdef TT_MISR_EN
    return misr_ref(t, n);
`else
    return 16'h0000;
`endif
  endfunction

  // Pulse start (optionally with abort, which start must override)
  task automatic launch(input bit both);
    @(posedge clk); #1;
    start_req = 1'b1;
    abort_req = both;
    @(posedge clk); #1;
    start_req = 1'b0;
    abort_req = 1'b0;
    check_eq("start_busy", o_busy, 1'b1);
    check_eq("start_x", o_x, 6'd0);
  endtask

  task automatic wait_x(input logic [5:0] target, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 500 && !ok; c++) begin
      if (o_x == target) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check_eq("wait_x_reached", ok, 1'b1);
  endtask

  task automatic run_sweep(input bit s, input logic [63:0] rt, input logic [63:0] mk, input bit both);
    int          cyc;
    bit          got;
    logic [63:0] ett;
    sel = s; ref_tbl = rt; err_mask = mk;
    launch(both);
    cyc = 0;
    got = 1'b0;
    while (cyc < 1000 && !got) begin
      @(posedge clk); #1;
      cyc++;
      if (o_done) got = 1'b1;
      else start_req = ($urandom_range(0, 7) == 0);
    end
    start_req = 1'b0;
    ett = rt ^ mk;
    check_eq("done_seen", got, 1'b1);
    check_eq("done_cycle", cyc, s ? 64 : 128);
    check_eq("tt", o_tt, ett);
    check_eq("mism_cnt", o_mism, $countones(mk));
    check_eq("first_valid", o_fv, mk != 64'd0);
    if (mk != 64'd0) check_eq("first_mism", o_first, lowest_set(mk));
    @(posedge clk); #1;
    check_eq("done_width", o_done, 1'b0);
    check_eq("end_busy", o_busy, 1'b0);
    check_eq("end_x", o_x, 6'd0);
    check_eq("pass", o_pass, mk == 64'd0);
    check_eq("sig", o_sig, exp_sig(ett, 64));
  endtask

  task automatic run_abort(input bit s, input logic [63:0] rt, input logic [63:0] mk);
    bit          ok;
    bit          seen_done;
    logic [63:0] ett;
    logic [63:0] part;
    sel = s; ref_tbl = rt; err_mask = mk;
    launch(1'b0);
    wait_x(6'd10, ok);
    abort_req = 1'b1;
    @(posedge clk); #1;
    abort_req = 1'b0;
    check_eq("abort_busy", o_busy, 1'b0);
    check_eq("abort_x", o_x, 6'd0);
    seen_done = o_done;
    repeat (4) begin
      @(posedge clk); #1;
      seen_done = seen_done | o_done;
    end
    check_eq("abort_no_done", seen_done, 1'b0);
    ett  = rt ^ mk;
    part = mk & 64'h3FF;
    check_eq("abort_tt", o_tt, ett & 64'h3FF);
    check_eq("abort_mism", o_mism, $countones(part));
    check_eq("abort_fv", o_fv, part != 64'd0);
    if (part != 64'd0) check_eq("abort_first", o_first, lowest_set(part));
    check_eq("abort_pass", o_pass, 1'b0);
    check_eq("abort_sig", o_sig, exp_sig(ett, 10));
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_busy"}, o_busy, 1'b0);
    check_eq({tag, "_x"}, o_x, 6'd0);
    check_eq({tag, "_done"}, o_done, 1'b0);
    check_eq({tag, "_tt"}, o_tt, 64'd0);
    check_eq({tag, "_mism"}, o_mism, 7'd0);
    check_eq({tag, "_first"}, o_first, 6'd0);
    check_eq({tag, "_fv"}, o_fv, 1'b0);
    check_eq({tag, "_pass"}, o_pass, 1'b0);
    check_eq({tag, "_sig"}, o_sig, 16'h0000);
  endtask

  logic [63:0] ptbl;
  logic [63:0] rmask;
  logic [5:0]  v;
  bit          ok;

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    start_req = 1'b0;
    abort_req = 1'b0;
    sel       = 1'b0;
    ref_tbl   = '0;
    err_mask  = '0;
    for (int i = 0; i < 64; i++) begin
      v       = 6'(i);
      ptbl[i] = ^v;
    end

    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst_a");
    sel = 1'b1; #1;
    check_reset_vals("rst_b");
    sel = 1'b0;
    @(negedge clk) rst_n = 1'b1;

    // Parity on both netlists: clean pass
    run_sweep(1'b0, ptbl, 64'd0, 1'b0);
    check_eq("tt_parity_const", o_tt, 64'h6996966996696996);

    // Single disagreement at vector 37
    run_sweep(1'b0, ptbl, 64'd1 << 37, 1'b0);
    check_eq("tt_bit37", o_tt[37], 1'b0);

    // Abort with the previous pass flag already cleared by start
    run_sweep(1'b0, ptbl, 64'd0, 1'b0);
    run_abort(1'b0, ptbl, 64'd1 << 3);

    // Every vector disagrees, zero settle
    run_sweep(1'b1, {$urandom, $urandom}, {64{1'b1}}, 1'b0);
    check_eq("mism_all", o_mism, 7'b1000000);

    // All-zero DUT output stream for the signature
    run_sweep(1'b0, 64'd0, 64'd0, 1'b0);

    // Random tables, sparse random faults, random instance, start+abort together
    for (int k = 0; k < 6; k++) begin
      rmask = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) rmask = 64'd0;
      run_sweep(1'($urandom_range(0, 1)), {$urandom, $urandom}, rmask, 1'($urandom_range(0, 1)));
    end

    run_abort(1'b1, {$urandom, $urandom}, {$urandom, $urandom});

    // Asynchronous reset mid-sweep, then a full clean sweep
    run_sweep(1'b0, ptbl, 64'd0, 1'b0);
    sel = 1'b0; ref_tbl = ptbl; err_mask = 64'd1 << 5;
    launch(1'b0);
    wait_x(6'd20, ok);
    #2 rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    @(negedge clk) rst_n = 1'b1;
    run_sweep(1'b0, {$urandom, $urandom}, 64'd1 << 63, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
